dpram_fifo_ctrl_2048_40bit: RTL and testbench

DPRAM_FIFO_CTRL_2048_40BIT -- requirements
Module: dpram_fifo_ctrl_2048_40bit

---
 rtl/dpram_fifo_ctrl_2048_40bit_if.sv | 41 ++++
 rtl/dpram_fifo_ctrl_2048_40bit.sv | 148 ++++++++++++++
 tb/tb_dpram_fifo_ctrl_2048_40bit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_2048_40bit_if.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl_2048_40bit_if
// Stream-side bundle of the 2048x40 dual-port-RAM FIFO controller.
//   in_valid / in_ready / in_data    : upstream push handshake
//   out_valid / out_ready / out_data : downstream pop handshake
//   count                            : total words held by the FIFO
// The slave modport is the FIFO controller. The master modport is the
// producer/consumer environment around it.
// ---------------------------------------------------------------------------
interface dpram_fifo_ctrl_2048_40bit_if #(
    parameter int DWIDTH = 40,
    parameter int CWIDTH = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic [CWIDTH-1:0] count;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );
endinterface

// File: rtl/dpram_fifo_ctrl_2048_40bit.sv
// ---------------------------------------------------------------------------
// dpram_fifo_ctrl_2048_40bit
// FIFO controller in front of an external 2048x40 dual-port RAM.
// - Port A writes only. Port B reads only, and its read data arrives one
//   cycle after the address is presented.
// - A two-entry output buffer sits behind the RAM read port. Together with
//   an in-flight flag, it lets the FIFO sustain one pop per cycle despite
//   the RAM read latency.
// Ports:
//   clk, reset          : sole clock (rising edge), async active-high reset
//   bus (slave)         : in_* push, out_* pop, count
//   ram_address_a/wren_a/data_a : RAM write port
//   ram_address_b/wren_b/data_b : RAM read port (wren_b/data_b tied to 0)
//   ram_out_b           : RAM read data, one cycle after ram_address_b
// ---------------------------------------------------------------------------
module dpram_fifo_ctrl_2048_40bit #(
    parameter int AWIDTH    = 11,
    parameter int NUM_WORDS = 2048,
    parameter int DWIDTH    = 40,
    parameter int CWIDTH    = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    dpram_fifo_ctrl_2048_40bit_if.slave bus,
    output logic [AWIDTH-1:0]      ram_address_a,
    output logic                   ram_wren_a,
    output logic [DWIDTH-1:0]      ram_data_a,
    output logic [AWIDTH-1:0]      ram_address_b,
    output logic                   ram_wren_b,
    output logic [DWIDTH-1:0]      ram_data_b,
    input  logic [DWIDTH-1:0]      ram_out_b
);

    logic [AWIDTH-1:0] wr_ptr_r;
    logic [AWIDTH-1:0] rd_ptr_r;
    logic [CWIDTH-1:0] ram_occ_r;
    logic              inflt_r;
    logic [1:0]        ob_cnt_r;
    logic [DWIDTH-1:0] ob0_r;
    logic [DWIDTH-1:0] ob1_r;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              issue_s;
    logic [2:0]        ob_pending_s;

    // Handshake and read-issue decisions, all derived from registered state
    always_comb begin
        in_ready_s   = 1'b0;
        out_valid_s  = 1'b0;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        ob_pending_s = 3'd0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (ram_occ_r < CWIDTH'(NUM_WORDS));
        end
        out_valid_s  = (ob_cnt_r != 2'd0);
        push_s       = bus.in_valid & in_ready_s;
        pop_s        = out_valid_s & bus.out_ready;
        // A read may issue only if its data has a buffer slot when it lands.
        // The slot count includes the slot freed by a pop this cycle.
        ob_pending_s = {1'b0, ob_cnt_r} + {2'b00, inflt_r};
        issue_s      = (ram_occ_r != {CWIDTH{1'b0}}) &&
                       (ob_pending_s < (3'd2 + {2'b00, pop_s}));
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = ob0_r;
    assign bus.count     = ram_occ_r + CWIDTH'(inflt_r) + CWIDTH'(ob_cnt_r);

    assign ram_wren_a    = push_s;
    assign ram_address_a = wr_ptr_r;
    assign ram_data_a    = bus.in_data;
    assign ram_address_b = rd_ptr_r;
    assign ram_wren_b    = 1'b0;
    assign ram_data_b    = {DWIDTH{1'b0}};

    // Write/read pointers, RAM occupancy and in-flight read flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= {AWIDTH{1'b0}};
            rd_ptr_r  <= {AWIDTH{1'b0}};
            ram_occ_r <= {CWIDTH{1'b0}};
            inflt_r   <= 1'b0;
        end else begin
            // Pointers are exactly AWIDTH bits wide, so 2047 wraps to 0 naturally
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AWIDTH'(1);
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + AWIDTH'(1);
            end
            case ({push_s, issue_s})
                2'b10:   ram_occ_r <= ram_occ_r + CWIDTH'(1);
                2'b01:   ram_occ_r <= ram_occ_r - CWIDTH'(1);
                default: ram_occ_r <= ram_occ_r;
            endcase
            inflt_r <= issue_s;
        end
    end

    // Two-entry output buffer: capture landing read data, shift on pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ob_cnt_r <= 2'd0;
            ob0_r    <= {DWIDTH{1'b0}};
            ob1_r    <= {DWIDTH{1'b0}};
        end else begin
            case ({inflt_r, pop_s})
                2'b10: begin
                    case (ob_cnt_r)
                        2'd0: begin
                            ob0_r    <= ram_out_b;
                            ob_cnt_r <= 2'd1;
                        end
                        2'd1: begin
                            ob1_r    <= ram_out_b;
                            ob_cnt_r <= 2'd2;
                        end
                        default: ob_cnt_r <= ob_cnt_r;
                    endcase
                end
                2'b01: begin
                    ob0_r    <= ob1_r;
                    ob_cnt_r <= ob_cnt_r - 2'd1;
                end
                2'b11: begin
                    // Capture and pop together: occupancy is unchanged and the new
                    // word lands behind whatever remains.
                    if (ob_cnt_r == 2'd1) begin
                        ob0_r <= ram_out_b;
                    end else begin
                        ob0_r <= ob1_r;
                        ob1_r <= ram_out_b;
                    end
                end
                default: ob_cnt_r <= ob_cnt_r;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl_2048_40bit.sv
module tb_dpram_fifo_ctrl_2048_40bit;

    logic        clk;
    logic        reset;
    logic [10:0] ram_address_a;
    logic        ram_wren_a;
    logic [39:0] ram_data_a;
    logic [10:0] ram_address_b;
    logic        ram_wren_b;
    logic [39:0] ram_data_b;
    logic [39:0] ram_out_b;
    logic [39:0] mem [0:2047];

    int n_vec;
    int n_err;
    logic [39:0] sb[$];

    dpram_fifo_ctrl_2048_40bit_if #(.DWIDTH(40), .CWIDTH(12)) bus ();

    dpram_fifo_ctrl_2048_40bit dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .ram_address_a (ram_address_a),
        .ram_wren_a    (ram_wren_a),
        .ram_data_a    (ram_data_a),
        .ram_address_b (ram_address_b),
        .ram_wren_b    (ram_wren_b),
        .ram_data_b    (ram_data_b),
        .ram_out_b     (ram_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External dual-port RAM: port A write, port B read with 1-cycle latency
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        if (!ram_wren_b) ram_out_b <= mem[ram_address_b];
    end

    // One cycle: drive at negedge, sample the handshake just after
    task automatic step(input logic iv, input logic [39:0] d, input logic ordy,
                        output logic pushed, output logic popped, output logic ovld,
                        output logic [39:0] odata, output logic [11:0] ocnt);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        pushed = iv & bus.in_ready;
        ovld   = bus.out_valid;
        popped = bus.out_valid & ordy;
        odata  = bus.out_data;
        ocnt   = bus.count;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 40'hDE_AD00_BEEF;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.count !== 12'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 40'd0) begin n_err++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_vec++; if (ram_wren_a !== 1'b0) begin n_err++; $display("FAIL reset_wren_a got %b want 0", ram_wren_a); end
        n_vec++; if (ram_wren_b !== 1'b0 || ram_data_b !== 40'd0) begin n_err++; $display("FAIL reset_port_b got wren=%b data=%h want 0/0", ram_wren_b, ram_data_b); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_single_word();
        logic p, q, v; logic [39:0] od; logic [11:0] oc;
        logic [39:0] w;
        int lat;
        w = 40'h12_3456_789A;
        lat = -1;
        step(1'b1, w, 1'b1, p, q, v, od, oc);
        if (p) sb.push_back(w);
        n_vec++; if (ram_wren_a !== 1'b1 || ram_address_a !== 11'd0 || ram_data_a !== w) begin
            n_err++; $display("FAIL single_write got wren=%b addr=%0d data=%h want 1/0/%h", ram_wren_a, ram_address_a, ram_data_a, w); end
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 40'd0, 1'b1, p, q, v, od, oc);
            if (q) begin
                lat = i;
                n_vec++;
                if (sb.size() == 0) begin n_err++; $display("FAIL single_data got %h want nothing", od); end
                else begin
                    logic [39:0] e;
                    e = sb.pop_front();
                    if (od !== e) begin n_err++; $display("FAIL single_data got %h want %h", od, e); end
                end
                break;
            end
        end
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL single_latency got %0d want 3", lat); end
        step(1'b0, 40'd0, 1'b1, p, q, v, od, oc);
        n_vec++; if (oc !== 12'd0 || v !== 1'b0) begin n_err++; $display("FAIL single_drained got count=%0d valid=%b want 0/0", oc, v); end
    endtask

    task automatic test_fill();
        logic p, q, v; logic [39:0] od; logic [11:0] oc;
        int accepted;
        int cyc;
        accepted = 0;
        for (int i = 0; i < 2060; i++) begin
            step(1'b1, 40'(i + 1000), 1'b0, p, q, v, od, oc);
            if (p) begin sb.push_back(40'(i + 1000)); accepted++; end
        end
        n_vec++; if (accepted != 2050) begin n_err++; $display("FAIL fill_accepted got %0d want 2050", accepted); end
        step(1'b1, 40'hFF_FFFF_FFFF, 1'b0, p, q, v, od, oc);
        if (p) sb.push_back(40'hFF_FFFF_FFFF);
        n_vec++; if (p !== 1'b0 || bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full got push=%b in_ready=%b want 0/0", p, bus.in_ready); end
        n_vec++; if (oc !== 12'd2050) begin n_err++; $display("FAIL fill_count got %0d want 2050", oc); end
        cyc = 0;
        while (sb.size() > 0 && cyc < 3000) begin
            step(1'b0, 40'd0, 1'b1, p, q, v, od, oc);
            if (q) begin
                logic [39:0] e;
                e = sb.pop_front();
                n_vec++; if (od !== e) begin n_err++; $display("FAIL fill_drain got %h want %h", od, e); end
            end
            cyc++;
        end
        n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL fill_drain_timeout got %0d left want 0", sb.size()); sb.delete(); end
        step(1'b0, 40'd0, 1'b0, p, q, v, od, oc);
        n_vec++; if (oc !== 12'd0 || v !== 1'b0) begin n_err++; $display("FAIL fill_empty got count=%0d valid=%b want 0/0", oc, v); end
    endtask

    task automatic test_streaming();
        logic p, q, v; logic [39:0] od; logic [11:0] oc;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0;
        while (recv < 5000 && cyc < 6000) begin
            step(sent < 5000, 40'(sent), 1'b1, p, q, v, od, oc);
            if (p) begin sb.push_back(40'(sent)); sent++; end
            if (q) begin
                logic [39:0] e;
                e = (sb.size() > 0) ? sb.pop_front() : 40'hX;
                n_vec++; if (od !== e) begin n_err++; $display("FAIL stream_data got %h want %h", od, e); end
                recv++;
            end
            cyc++;
        end
        n_vec++; if (recv != 5000) begin n_err++; $display("FAIL stream_count got %0d want 5000", recv); end
        n_vec++; if (cyc > 5004) begin n_err++; $display("FAIL stream_throughput got %0d cycles want <= 5004", cyc); end
        sb.delete();
    endtask

    task automatic test_backpressure();
        logic p, q, v; logic [39:0] od; logic [11:0] oc;
        logic hold_prev;
        logic [39:0] data_prev;
        logic [39:0] d;
        int sent, recv, cyc;
        logic iv, ordy;
        sent = 0; recv = 0; cyc = 0; hold_prev = 1'b0; data_prev = 40'd0;
        while (recv < 10000 && cyc < 60000) begin
            iv   = (sent < 10000) && ($urandom_range(99) < 70);
            ordy = ($urandom_range(99) < 50);
            d    = {8'($urandom), 32'($urandom)};
            step(iv, d, ordy, p, q, v, od, oc);
            n_vec++; if (oc !== 12'(sb.size())) begin n_err++; $display("FAIL bp_count got %0d want %0d", oc, sb.size()); end
            if (hold_prev && v) begin
                n_vec++; if (od !== data_prev) begin n_err++; $display("FAIL bp_stable got %h want %h", od, data_prev); end
            end
            hold_prev = v & ~ordy;
            data_prev = od;
            if (p) begin sb.push_back(d); sent++; end
            if (q) begin
                logic [39:0] e;
                e = (sb.size() > 0) ? sb.pop_front() : 40'hX;
                n_vec++; if (od !== e) begin n_err++; $display("FAIL bp_data got %h want %h", od, e); end
                recv++;
            end
            cyc++;
        end
        n_vec++; if (recv != 10000) begin n_err++; $display("FAIL bp_received got %0d want 10000", recv); end
        sb.delete();
    endtask

    task automatic test_reset_midstream();
        logic p, q, v; logic [39:0] od; logic [11:0] oc;
        int got;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 40'(i + 7), 1'b0, p, q, v, od, oc);
            if (p) sb.push_back(40'(i + 7));
        end
        // Pop and push together: the pop frees a slot so a read issues
        step(1'b1, 40'h77, 1'b1, p, q, v, od, oc);
        if (p) sb.push_back(40'h77);
        if (q) void'(sb.pop_front());
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        n_vec++; if (bus.count !== 12'd100) begin n_err++; $display("FAIL mid_count_before got %0d want 100", bus.count); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus.count !== 12'd0 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got count=%0d valid=%b want 0/0", bus.count, bus.out_valid); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.count !== 12'd0) begin
            n_err++; $display("FAIL mid_after got ready=%b valid=%b count=%0d want 1/0/0", bus.in_ready, bus.out_valid, bus.count); end
        sb.delete();
        step(1'b1, 40'hA5, 1'b1, p, q, v, od, oc);
        if (p) sb.push_back(40'hA5);
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step(1'b0, 40'd0, 1'b1, p, q, v, od, oc);
            if (q) begin
                logic [39:0] e;
                e = (sb.size() > 0) ? sb.pop_front() : 40'hX;
                got = 1;
                n_vec++; if (od !== e) begin n_err++; $display("FAIL mid_first_out got %h want %h", od, e); end
            end
        end
        n_vec++; if (got != 1) begin n_err++; $display("FAIL mid_first_timeout got none want 40'hA5"); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_word();
        test_fill();
        test_streaming();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
